gravacao_recorder: RTL and testbench

Record/playback core of the gravacao Tiny Tapeout design; sits directly downstream of the tt_um_gravacao pin wrapper.
- The wrapper maps ui_in/uio_in to its command and data inputs, and its outputs to uo_out/uio_out.
- Captures a burst of 8-bit samples into a small on-chip buffer.
- Replays them at a programmable rate, once or looped.

---
 rtl/gravacao_pkg.sv | 24 ++
 rtl/gravacao_mem.sv | 37 +++
 rtl/gravacao_recorder.sv | 151 +++++++++++++++
 tb/tb_gravacao_recorder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gravacao_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gravacao_pkg
//  Description : Shared definitions for the gravacao record/playback core:
//                state encoding and the default buffer depth and playback
//                rate that the pin wrapper also uses.
//  Revision    : 1.0  initial release
// ============================================================================
package gravacao_pkg;

    // Default sizing shared with the tt_um_gravacao wrapper
    localparam int GRV_DEPTH    = 16;
    localparam int GRV_ADDR_W   = 4;
    localparam int GRV_RATE_DIV = 4;

    // State encoding; the numeric values are visible on state_o
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

endpackage : gravacao_pkg
`default_nettype wire

// File: rtl/gravacao_mem.sv
`default_nettype none
// ============================================================================
//  Module      : gravacao_mem
//  Description : DEPTH x 8 sample register file. Synchronous write,
//                combinational (asynchronous) read. Contents are never reset.
//  Ports       : clk      - system clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address
//                o_rdata  - read data (combinational from i_raddr)
//  Revision    : 1.0  initial release
// ============================================================================
module gravacao_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : gravacao_mem
`default_nettype wire

// File: rtl/gravacao_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : gravacao_recorder
//  Description : Record/playback core. Captures a burst of 8-bit samples into
//                a DEPTH-entry buffer and replays them one sample every
//                RATE_DIV clocks, either once or looped.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                rec_start         - pulse: start a new recording
//                play_start        - pulse: start playback (needs length>0)
//                stop              - pulse: abort record or play
//                loop_en           - level: loop at end of buffer
//                in_valid, in_data - sample strobe and value while recording
//                out_valid         - one-cycle pulse per played sample
//                out_data          - played sample, held between pulses
//                state_o           - 0 IDLE, 1 RECORD, 2 PLAY
//                length            - number of stored samples, 0..DEPTH
//                full              - length == DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module gravacao_recorder
    import gravacao_pkg::*;
#(
    parameter int DEPTH    = GRV_DEPTH,
    parameter int ADDR_W   = GRV_ADDR_W,
    parameter int RATE_DIV = GRV_RATE_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   length,
    output logic              full
);

    localparam int              c_DIV_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RATE_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_LEN_ONE  = (ADDR_W + 1)'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_length;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [c_DIV_W-1:0]  r_div;
    logic                r_out_valid;
    logic [7:0]          r_out_data;

    logic                w_we;
    logic [ADDR_W-1:0]   w_wr_ptr;
    logic [ADDR_W:0]     w_len_inc;
    logic [ADDR_W:0]     w_rd_next;
    logic                w_last;
    logic [7:0]          w_rdata;

    // Write pointer is simply the low bits of length: recording always
    // starts from slot 0 and never wraps.
    assign w_wr_ptr  = r_length[ADDR_W-1:0];
    assign w_len_inc = r_length + c_LEN_ONE;
    assign w_we      = !rst && (r_state == ST_RECORD) && in_valid;

    // The slot being read is the last stored one when rd_ptr+1 == length
    assign w_rd_next = {1'b0, r_rd_ptr} + c_LEN_ONE;
    assign w_last    = (w_rd_next == r_length);

    gravacao_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_length    <= '0;
            r_rd_ptr    <= '0;
            r_div       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rec_start) begin
                        r_state  <= ST_RECORD;
                        r_length <= '0;
                    end else if (play_start && (r_length != '0)) begin
                        r_state  <= ST_PLAY;
                        r_rd_ptr <= '0;
                        r_div    <= '0;
                    end
                end
                ST_RECORD: begin
                    // A sample arriving together with stop is still kept
                    if (in_valid) begin
                        r_length <= w_len_inc;
                        if (w_len_inc == c_DEPTH) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    // stop outranks an emit due in the same cycle
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (r_div == c_DIV_LAST) begin
                        r_div       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_rdata;
                        if (w_last) begin
                            r_rd_ptr <= '0;
                            if (!loop_en) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_rd_ptr <= w_rd_next[ADDR_W-1:0];
                        end
                    end else begin
                        r_div <= r_div + c_DIV_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign state_o   = r_state;
    assign length    = r_length;
    assign full      = (r_length == c_DEPTH);

endmodule : gravacao_recorder
`default_nettype wire

// File: tb/tb_gravacao_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gravacao_recorder
//  Description : Directed self-checking bench for gravacao_recorder
//                (DEPTH=16, RATE_DIV=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gravacao_recorder;

    localparam int RD = 4;

    logic       clk;
    logic       rst;
    logic       rec_start;
    logic       play_start;
    logic       stop;
    logic       loop_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] state_o;
    logic [4:0] length;
    logic       full;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned exp_q[$];

    gravacao_recorder #(
        .DEPTH    (16),
        .ADDR_W   (4),
        .RATE_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop_en    (loop_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .state_o    (state_o),
        .length     (length),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run 'cycles' clocks after the play_start edge, checking each cycle
    // against the expected samples in exp_q (one every RD clocks).
    task automatic play_run(input int cycles, input bit looped);
        int n;
        int idx;
        bit pulse;
        n = exp_q.size();
        for (int k = 1; k <= cycles; k++) begin
            tick();
            idx   = k / RD;
            pulse = ((k % RD) == 0) && (looped || idx <= n);
            chk($sformatf("out_valid k=%0d", k), int'(out_valid), int'(pulse));
            if (pulse) begin
                chk($sformatf("out_data k=%0d", k), int'(out_data),
                    int'(exp_q[(idx - 1) % n]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
        loop_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // ---- 1: reset values, record 3, play once ----
        chk("rst state", int'(state_o), 0);
        chk("rst length", int'(length), 0);
        chk("rst full", int'(full), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_data", int'(out_data), 0);

        rec_start = 1'b1; tick(); rec_start = 1'b0;
        chk("t1 state rec", int'(state_o), 1);
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        chk("t1 length", int'(length), 3);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t1 state stop", int'(state_o), 0);
        chk("t1 length kept", int'(length), 3);
        play_start = 1'b1; tick(); play_start = 1'b0;
        chk("t1 state play", int'(state_o), 2);
        exp_q = '{8'h11, 8'h22, 8'h33};
        play_run(20, 1'b0);
        chk("t1 state end", int'(state_o), 0);
        chk("t1 length end", int'(length), 3);

        // ---- 2: overfill, stops at DEPTH ----
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (i == 15) begin
                chk("t2 length16", int'(length), 16);
                chk("t2 full", int'(full), 1);
                chk("t2 state idle", int'(state_o), 0);
            end
        end
        in_valid = 1'b0;
        chk("t2 length after drop", int'(length), 16);
        play_start = 1'b1; tick(); play_start = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        play_run(72, 1'b0);
        chk("t2 state end", int'(state_o), 0);

        // ---- 3: looped play, stop on the emit cycle ----
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        chk("t3 full cleared", int'(full), 0);
        in_valid = 1'b1;
        in_data = 8'hA0; tick();
        in_data = 8'hA1; tick();
        in_valid = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        loop_en = 1'b1;
        play_start = 1'b1; tick(); play_start = 1'b0;
        exp_q = '{8'hA0, 8'hA1};
        play_run(19, 1'b1);
        // Divider is now at its last count; stop must suppress this emit
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t3 stop no pulse", int'(out_valid), 0);
        chk("t3 state idle", int'(state_o), 0);
        chk("t3 out_data held", int'(out_data), 8'hA1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t3 quiet", int'(out_valid), 0);
        end
        loop_en = 1'b0;

        // ---- 4: empty play ignored, rec_start wins ----
        rst = 1'b1; tick(); rst = 1'b0;
        play_start = 1'b1; tick(); play_start = 1'b0;
        chk("t4 empty play state", int'(state_o), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4 empty quiet", int'(out_valid), 0);
        end
        rec_start = 1'b1; play_start = 1'b1; tick();
        rec_start = 1'b0; play_start = 1'b0;
        chk("t4 rec wins", int'(state_o), 1);

        // ---- 5: sample in the stop cycle is kept ----
        in_valid = 1'b1; in_data = 8'h01; tick();
        in_data = 8'h5A; stop = 1'b1; tick();
        in_valid = 1'b0; stop = 1'b0;
        chk("t5 state", int'(state_o), 0);
        chk("t5 length", int'(length), 2);
        play_start = 1'b1; tick(); play_start = 1'b0;
        exp_q = '{8'h01, 8'h5A};
        play_run(12, 1'b0);
        chk("t5 state end", int'(state_o), 0);

        // ---- 6: reset mid-play ----
        play_start = 1'b1; tick(); play_start = 1'b0;
        for (int i = 0; i < RD; i++) tick();
        chk("t6 pulse before rst", int'(out_valid), 1);
        chk("t6 data before rst", int'(out_data), 8'h01);
        rst = 1'b1; play_start = 1'b1; tick();
        rst = 1'b0; play_start = 1'b0;
        chk("t6 state", int'(state_o), 0);
        chk("t6 length", int'(length), 0);
        chk("t6 out_valid", int'(out_valid), 0);
        chk("t6 out_data", int'(out_data), 0);
        play_start = 1'b1; tick(); play_start = 1'b0;
        chk("t6 play ignored", int'(state_o), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6 quiet", int'(out_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gravacao_recorder
`default_nettype wire
